rtype_sequencer: RTL
====================

// Module: rtype_sequencer
// PURPOSE
//   Multicycle controller that runs a program of MIPS R-type instructions through the R-type
//   datapath (DPTR). Fetches words from a synchronous instruction ROM, decodes and validates them,
//   holds each one stable on the datapath, and pulses the register-file write enable.
//   Also tracks retired instructions and the datapath zero flag.
//   Sits between the instruction memory and DPTR; start/done handshake to the top level.
// PARAMETERS
//   ADDR_W   5   word-address width of the instruction ROM
//   PROG_LEN 32  max instructions executed per run (1..2**ADDR_W)
//   CNT_W    8   width of instr_count
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   start        in   1       1-cycle request: run the program from address 0
//   imem_addr    out  ADDR_W  ROM word address (= PC)
//   imem_data    in   32      ROM data, valid the cycle after imem_addr is presented
//   dp_instr     out  32      instruction held on the DPTR instruction input
//   dp_we        out  1       DPTR register-file write enable, 1 cycle per retired instr
//   dp_zf        in   1       DPTR zero flag
//   busy         out  1       high in every state except IDLE
//   done         out  1       1-cycle pulse at normal end of run
//   err          out  1       sticky; unsupported instruction found; cleared by next accepted start
//   zf_last      out  1       dp_zf captured in WB of the last retired instr
//   instr_count  out  CNT_W   instructions retired this run; saturates at all-ones
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, PC=0, dp_instr=0, dp_we=0, busy=0, done=0, err=0,
//     zf_last=0, instr_count=0. Operation is aborted immediately and no write is issued.
//   FSM: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH ... ; DONE and ERROR are exits.
//   IDLE:   imem_addr=PC. start=1 -> PC=0, instr_count=0, err=0, zf_last=0; go to FETCH.
//   FETCH:  imem_addr=PC; go to DECODE.
//   DECODE: imem_data registered into instr reg (drives dp_instr). Checks:
//     - word==32'h0000_0000 -> end marker -> DONE (not counted).
//     - opcode[31:26]!=0 or shamt[10:6]!=0 or funct not in {0x20 add, 0x22 sub,
//       0x24 and, 0x25 or, 0x2A slt} -> ERROR (not counted).
//     - otherwise -> EXEC.
//   EXEC:   1 settle cycle with dp_instr stable; dp_we=0.
//   WB:     dp_we=1, unless rd[15:11]==0 (write suppressed, still retired).
//     zf_last<=dp_zf; instr_count++ (saturating); PC++.
//     If the new retired count == PROG_LEN -> DONE; else -> FETCH.
//   DONE:   done=1 for exactly one cycle; go to IDLE.
//   ERROR:  err<=1; go to IDLE. No done pulse.
//   Latency: 4 cycles per retired instruction (FETCH, DECODE, EXEC, WB).
//   Handshake:
//     - start ignored unless in IDLE (including the DONE/ERROR cycle).
//     - start held high re-triggers on each visit to IDLE.
//   Counters and flags:
//     - dp_instr holds the last decoded word until the next DECODE or reset.
//     - busy=1 in FETCH..WB, DONE and ERROR.
//   PC wrap:
//     - PROG_LEN ends the run before PC exceeds 2**ADDR_W-1.
//     - If PROG_LEN==2**ADDR_W, PC wraps to 0 after the final WB; it is not used afterwards.
// TESTING
//   1 ROM={01E9A022,0289A822,00AFB020,012FB820,028FC02A,0}; start pulse -> 5 dp_we pulses,
//     4 cycles apart; done exactly 23 cycles after the start edge; instr_count=5, err=0.
//   2 ROM[2]=8C000000 (lw) -> 2 retired; err=1; no done pulse; busy=0 next cycle; dp_we never
//     seen for addr 2.
//   3 ROM[0]=00000020 (add rd=0) -> no dp_we pulse in WB, instr_count increments to 1.
//   4 PROG_LEN=4, ROM filled with valid add words -> done after 4 retired, PC never fetches
//     address 4; start held high -> second run starts the cycle after IDLE, instr_count restarts at 0.
//   5 Assert rst during EXEC of instr 2 -> all outputs to reset values within the same cycle,
//     no dp_we; release rst and start -> run restarts at imem_addr=0.
//   6 Force dp_zf=1 in last WB, 0 elsewhere -> zf_last=1 at done; start during busy ignored.

Source files
------------

// File: rtl/rtype_sequencer.sv
// Multicycle sequencer: runs MIPS R-type words from a synchronous ROM
// through the R-type datapath (fetch, decode/validate, settle, write back).
module rtype_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       dp_instr,
  output logic              dp_we,
  input  logic              dp_zf,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              zf_last,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_DONE,
    S_ERROR
  } state_t;

  // PC also counts retirements of the current run, so it decides run end
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(PROG_LEN);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   pc_inc;
  logic              funct_ok;
  logic              legal;
  logic              is_end;

  assign imem_addr = pc;
  assign pc_inc    = {1'b0, pc} + (ADDR_W+1)'(1);
  assign is_end    = (imem_data == 32'h0);

  always_comb begin
    funct_ok = 1'b0;
    case (imem_data[5:0])
      6'h20, 6'h22, 6'h24,
      6'h25, 6'h2A: funct_ok = 1'b1;
      default:      funct_ok = 1'b0;
    endcase
  end

  assign legal = (imem_data[31:26] == 6'd0)
              && (imem_data[10:6] == 5'd0)
              && funct_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      dp_instr    <= '0;
      dp_we       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      zf_last     <= 1'b0;
      instr_count <= '0;
    end else begin
      dp_we <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            err         <= 1'b0;
            zf_last     <= 1'b0;
            busy        <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          dp_instr <= imem_data;
          if (is_end) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (!legal) begin
            state <= S_ERROR;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // rd == 0 still retires, but the register file is left untouched
          dp_we <= (dp_instr[15:11] != 5'd0);
          state <= S_WB;
        end
        S_WB: begin
          zf_last <= dp_zf;
          if (instr_count != '1)
            instr_count <= instr_count + CNT_W'(1);
          pc <= pc_inc[ADDR_W-1:0];
          if (pc_inc == LAST) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERROR: begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
